// File: rtl/multicycle_control_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm_if
// Bundle between the instruction register / datapath and the multicycle
// control FSM.
//   Opcode, Funct        : instruction fields presented to the controller
//   IorD .. PCWriteCond  : single-bit datapath strobes
//   ALUSrcB, ALUOp,
//   PCSource             : 2-bit datapath selects
//   BranchNE             : branch polarity qualifier for PCWriteCond
//   ExcPC, EPCWrite      : exception vector load / EPC save
//   State                : current FSM state, debug visibility
// Modports: master = datapath side (drives instruction fields),
//           slave  = controller side (drives strobes).
// ---------------------------------------------------------------------------
interface multicycle_control_fsm_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemToReg;
    logic       IRWrite;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       PCWrite;
    logic       PCWriteCond;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       BranchNE;
    logic       ExcPC;
    logic       EPCWrite;
    logic [3:0] State;

    modport master (
        output Opcode, Funct,
        input  IorD, MemRead, MemWrite, MemToReg, IRWrite, RegDst, RegWrite,
               ALUSrcA, PCWrite, PCWriteCond, ALUSrcB, ALUOp, PCSource,
               BranchNE, ExcPC, EPCWrite, State
    );

    modport slave (
        input  Opcode, Funct,
        output IorD, MemRead, MemWrite, MemToReg, IRWrite, RegDst, RegWrite,
               ALUSrcA, PCWrite, PCWriteCond, ALUSrcB, ALUOp, PCSource,
               BranchNE, ExcPC, EPCWrite, State
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
// Moore control unit for a multicycle MIPS datapath (lw, sw, R-type, jr,
// beq, bne, j, addi). Memory states (FETCH, MEMRD, MEMWR) each last
// MEM_LATENCY+1 cycles, paced by a wait counter.
// Ports:
//   Clk    : single clock, rising edge
//   reset  : synchronous, active-high; forces every output to 0 while high
//   bus    : multicycle_control_fsm_if.slave (instruction fields in,
//            datapath strobes and debug State out)
// Parameters:
//   MEM_LATENCY : extra wait cycles per memory state
//   CNT_W       : wait counter width (MEM_LATENCY < 2**CNT_W)
// Optional feature macro: CTRL_EXCEPTION_EN
//   defined   -> illegal instructions go through EXC (PCWrite, ExcPC, EPCWrite)
//   undefined -> illegal instructions fall back to FETCH (NOP)
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int MEM_LATENCY = 0,
    parameter int CNT_W       = 4
) (
    input  logic                      Clk,
    input  logic                      reset,
    multicycle_control_fsm_if.slave   bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_JR     = 4'd12,
        S_EXC    = 4'd13
    } state_t;

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bne_q, bne_d;   // latched in DECODE, used by BRANCH
    logic             sw_q, sw_d;     // latched in DECODE, steers MEMADR

    logic last_wait;
    logic in_mem;

    assign last_wait = (cnt_q == LAT);
    assign in_mem    = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                       (state_q == S_MEMWR);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            bne_q   <= 1'b0;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bne_q   <= bne_d;
            sw_q    <= sw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bne_d   = bne_q;
        sw_d    = sw_q;
        case (state_q)
            S_FETCH:  if (last_wait) state_d = S_DECODE;
            S_DECODE: begin
                bne_d = (bus.Opcode == 6'h05);
                sw_d  = (bus.Opcode == 6'h2B);
                case (bus.Opcode)
                    6'h23, 6'h2B: state_d = S_MEMADR;
                    6'h00:        state_d = (bus.Funct == 6'h08) ? S_JR : S_RTEXEC;
                    6'h04, 6'h05: state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
                    6'h08:        state_d = S_IEXEC;
`ifdef CTRL_EXCEPTION_EN
                    default:      state_d = S_EXC;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_d = sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (last_wait) state_d = S_MEMWB;
            S_MEMWR:  if (last_wait) state_d = S_FETCH;
            S_RTEXEC: state_d = S_RTWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase

        // Counter restarts on every state change; it only ever advances
        // inside a memory state, so non-memory states see it at zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (in_mem && !last_wait) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Moore outputs; everything is gated off while reset is high.
    always_comb begin
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        bus.BranchNE    = 1'b0;
        bus.ExcPC       = 1'b0;
        bus.EPCWrite    = 1'b0;
        bus.State       = 4'd0;
        if (!reset) begin
            bus.State = state_q;
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = last_wait;
                    bus.PCWrite = last_wait;
                end
                S_DECODE: bus.ALUSrcB = 2'b11;
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                S_MEMWB: begin
                    bus.MemToReg = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_RTEXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 2'b10;
                end
                S_RTWB: begin
                    bus.RegDst   = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                    bus.BranchNE    = bne_q;
                end
                S_JUMP: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'b10;
                end
                S_IEXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_IWB: bus.RegWrite = 1'b1;
                S_JR: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'b11;
                end
`ifdef CTRL_EXCEPTION_EN
                S_EXC: begin
                    bus.PCWrite  = 1'b1;
                    bus.ExcPC    = 1'b1;
                    bus.EPCWrite = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
